// File: rtl/ex_operand_if.sv
// Bundle of ID-stage, forwarding, flag and ALU-side signals around the EX operand stage.
// The master drives the ID/forwarding inputs; the slave is the stage itself.
interface ex_operand_if #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 3,
  parameter int FLAGS_W = 3
);
  logic               stall;
  logic               flush;
  logic               id_valid;
  logic [3:0]         id_opcode;
  logic [DATA_W-1:0]  id_rdata_a;
  logic [DATA_W-1:0]  id_rdata_b;
  logic [IDX_W-1:0]   id_ra_idx;
  logic [IDX_W-1:0]   id_rb_idx;
  logic [DATA_W-1:0]  id_imm;
  logic               id_use_imm;
  logic               id_wr_en;
  logic [IDX_W-1:0]   id_wr_idx;
  logic               id_flag_we;
  logic               exm_wr_en;
  logic [IDX_W-1:0]   exm_wr_idx;
  logic [DATA_W-1:0]  exm_result;
  logic               wb_wr_en;
  logic [IDX_W-1:0]   wb_wr_idx;
  logic [DATA_W-1:0]  wb_result;
  logic [FLAGS_W-1:0] alu_flags;
  logic [3:0]         alu_opcode;
  logic [DATA_W-1:0]  alu_operand_a;
  logic [DATA_W-1:0]  alu_operand_b;
  logic               ex_valid;
  logic               ex_wr_en;
  logic [IDX_W-1:0]   ex_wr_idx;
  logic [FLAGS_W-1:0] flags_q;

  modport master (
    output stall, flush, id_valid, id_opcode, id_rdata_a, id_rdata_b, id_ra_idx, id_rb_idx,
           id_imm, id_use_imm, id_wr_en, id_wr_idx, id_flag_we,
           exm_wr_en, exm_wr_idx, exm_result, wb_wr_en, wb_wr_idx, wb_result, alu_flags,
    input  alu_opcode, alu_operand_a, alu_operand_b, ex_valid, ex_wr_en, ex_wr_idx, flags_q
  );

  modport slave (
    input  stall, flush, id_valid, id_opcode, id_rdata_a, id_rdata_b, id_ra_idx, id_rb_idx,
           id_imm, id_use_imm, id_wr_en, id_wr_idx, id_flag_we,
           exm_wr_en, exm_wr_idx, exm_result, wb_wr_en, wb_wr_idx, wb_result, alu_flags,
    output alu_opcode, alu_operand_a, alu_operand_b, ex_valid, ex_wr_en, ex_wr_idx, flags_q
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with combinational operand forwarding into the ALU
// and the architectural {NF,ZF,CF} flags register.
module ex_operand_stage #(
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 3,
  parameter int FLAGS_W = 3,
  parameter bit R0_ZERO = 1'b1
) (
  input logic          clk,
  input logic          rst,
  ex_operand_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [IDX_W-1:0]  ra_idx;
    logic [IDX_W-1:0]  rb_idx;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              flag_we;
  } idex_t;

  idex_t              r_ex;
  idex_t              w_load;
  logic [FLAGS_W-1:0] r_flags;

  logic w_a_zero, w_a_exm, w_a_wb;
  logic w_b_zero, w_b_exm, w_b_wb;
  logic [DATA_W-1:0] w_operand_a;
  logic [DATA_W-1:0] w_operand_b;

  // Control bits are qualified by id_valid so an invalid slot can never write.
  always_comb begin
    w_load         = '0;
    w_load.valid   = bus.id_valid;
    w_load.opcode  = bus.id_opcode;
    w_load.rdata_a = bus.id_rdata_a;
    w_load.rdata_b = bus.id_rdata_b;
    w_load.ra_idx  = bus.id_ra_idx;
    w_load.rb_idx  = bus.id_rb_idx;
    w_load.imm     = bus.id_imm;
    w_load.use_imm = bus.id_use_imm;
    w_load.wr_en   = bus.id_wr_en & bus.id_valid;
    w_load.wr_idx  = bus.id_wr_idx;
    w_load.flag_we = bus.id_flag_we & bus.id_valid;
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex    <= '0;
      r_flags <= '0;
    end else begin
      // Flags follow the instruction leaving EX, independent of flush.
      if (r_ex.valid && r_ex.flag_we && !bus.stall)
        r_flags <= bus.alu_flags;
      if (bus.flush)
        r_ex <= '0;
      else if (!bus.stall)
        r_ex <= w_load;
    end
  end

  // EX/MEM is checked before MEM/WB because it carries the younger result.
  assign w_a_zero = R0_ZERO && (r_ex.ra_idx == '0);
  assign w_a_exm  = bus.exm_wr_en && (bus.exm_wr_idx == r_ex.ra_idx);
  assign w_a_wb   = bus.wb_wr_en  && (bus.wb_wr_idx  == r_ex.ra_idx);
  assign w_b_zero = R0_ZERO && (r_ex.rb_idx == '0);
  assign w_b_exm  = bus.exm_wr_en && (bus.exm_wr_idx == r_ex.rb_idx);
  assign w_b_wb   = bus.wb_wr_en  && (bus.wb_wr_idx  == r_ex.rb_idx);

  always_comb begin
    w_operand_a = r_ex.rdata_a;
    if (w_a_zero)     w_operand_a = '0;
    else if (w_a_exm) w_operand_a = bus.exm_result;
    else if (w_a_wb)  w_operand_a = bus.wb_result;
  end

  always_comb begin
    w_operand_b = r_ex.rdata_b;
    if (r_ex.use_imm) w_operand_b = r_ex.imm;
    else if (w_b_zero) w_operand_b = '0;
    else if (w_b_exm)  w_operand_b = bus.exm_result;
    else if (w_b_wb)   w_operand_b = bus.wb_result;
  end

  assign bus.alu_opcode    = r_ex.opcode;
  assign bus.alu_operand_a = w_operand_a;
  assign bus.alu_operand_b = w_operand_b;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_wr_en      = r_ex.wr_en & r_ex.valid;
  assign bus.ex_wr_idx     = r_ex.wr_idx;
  assign bus.flags_q       = r_flags;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, forwarding priority, immediate/R0,
// stall/flush, flags register and a back-to-back dependent chain.
module tb_ex_operand_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ex_operand_if bus ();

  ex_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic valid, input logic [3:0] op,
                          input logic [2:0] ra, input logic [15:0] rda,
                          input logic [2:0] rb, input logic [15:0] rdb,
                          input logic use_imm, input logic [15:0] imm,
                          input logic wr_en, input logic [2:0] wr_idx, input logic flag_we);
    bus.id_valid   = valid;
    bus.id_opcode  = op;
    bus.id_ra_idx  = ra;
    bus.id_rdata_a = rda;
    bus.id_rb_idx  = rb;
    bus.id_rdata_b = rdb;
    bus.id_use_imm = use_imm;
    bus.id_imm     = imm;
    bus.id_wr_en   = wr_en;
    bus.id_wr_idx  = wr_idx;
    bus.id_flag_we = flag_we;
  endtask

  task automatic no_fwd();
    bus.exm_wr_en  = 1'b0;
    bus.exm_wr_idx = '0;
    bus.exm_result = '0;
    bus.wb_wr_en   = 1'b0;
    bus.wb_wr_idx  = '0;
    bus.wb_result  = '0;
  endtask

  logic [15:0] r1_model;
  logic [15:0] prev_result;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.alu_flags = '0;
    no_fwd();
    drive_id(1'b1, 4'hF, 3'd5, 16'hDEAD, 3'd6, 16'hBEEF, 1'b0, 16'h1111, 1'b1, 3'd7, 1'b1);

    // 1 Reset
    tick();
    tick();
    check("rst_valid", bus.ex_valid, 1'b0);
    check("rst_wr_en", bus.ex_wr_en, 1'b0);
    check("rst_flags", bus.flags_q, 3'b000);
    check("rst_opa", bus.alu_operand_a, 16'h0000);
    check("rst_opb", bus.alu_operand_b, 16'h0000);
    check("rst_opcode", bus.alu_opcode, 4'h0);
    rst = 1'b0;

    // 2 EX/MEM forwarding, priority over MEM/WB
    drive_id(1'b1, 4'h1, 3'd2, 16'h0001, 3'd1, 16'h0005, 1'b0, 16'h0000, 1'b1, 3'd2, 1'b0);
    tick();
    bus.exm_wr_en = 1'b1; bus.exm_wr_idx = 3'd2; bus.exm_result = 16'h1234;
    #1 check("exm_fwd_a", bus.alu_operand_a, 16'h1234);
    bus.wb_wr_en = 1'b1; bus.wb_wr_idx = 3'd2; bus.wb_result = 16'hBEEF;
    #1 check("exm_over_wb", bus.alu_operand_a, 16'h1234);
    bus.exm_wr_en = 1'b0;
    #1 check("wb_fwd_a", bus.alu_operand_a, 16'hBEEF);
    bus.wb_wr_en = 1'b0;
    #1 check("rf_a", bus.alu_operand_a, 16'h0001);
    check("rf_b", bus.alu_operand_b, 16'h0005);
    check("ld_opcode", bus.alu_opcode, 4'h1);
    check("ld_valid", bus.ex_valid, 1'b1);
    check("ld_wr_en", bus.ex_wr_en, 1'b1);
    check("ld_wr_idx", bus.ex_wr_idx, 3'd2);
    no_fwd();

    // 3 Immediate blocks forwarding on B; R0 is hard zero
    drive_id(1'b1, 4'h2, 3'd0, 16'h7777, 3'd3, 16'h3333, 1'b1, 16'h00FF, 1'b0, 3'd0, 1'b0);
    tick();
    bus.exm_wr_en = 1'b1; bus.exm_wr_idx = 3'd3; bus.exm_result = 16'hAAAA;
    #1 check("imm_b", bus.alu_operand_b, 16'h00FF);
    bus.exm_wr_idx = 3'd0; bus.exm_result = 16'h5555;
    bus.wb_wr_en = 1'b1; bus.wb_wr_idx = 3'd0; bus.wb_result = 16'h6666;
    #1 check("r0_a", bus.alu_operand_a, 16'h0000);
    no_fwd();
    #1 check("r0_a_nofwd", bus.alu_operand_a, 16'h0000);

    // id_valid=0 must not leave a write enable behind
    drive_id(1'b0, 4'h3, 3'd1, 16'h0000, 3'd1, 16'h0000, 1'b0, 16'h0000, 1'b1, 3'd3, 1'b1);
    tick();
    check("inv_valid", bus.ex_valid, 1'b0);
    check("inv_wr_en", bus.ex_wr_en, 1'b0);

    // 4 Stall holds, flush overrides stall
    drive_id(1'b1, 4'h5, 3'd1, 16'h0011, 3'd2, 16'h0022, 1'b0, 16'h0000, 1'b1, 3'd4, 1'b0);
    tick();
    check("pre_stall_a", bus.alu_operand_a, 16'h0011);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 4'(i + 8), 3'd3, 16'(16'h0100 + i), 3'd4, 16'h0900, 1'b0, 16'h0000, 1'b1, 3'd7, 1'b1);
      tick();
      check("stall_a", bus.alu_operand_a, 16'h0011);
      check("stall_b", bus.alu_operand_b, 16'h0022);
      check("stall_opcode", bus.alu_opcode, 4'h5);
      check("stall_wr_idx", bus.ex_wr_idx, 3'd4);
      check("stall_valid", bus.ex_valid, 1'b1);
    end
    bus.flush = 1'b1;
    tick();
    check("flush_valid", bus.ex_valid, 1'b0);
    check("flush_wr_en", bus.ex_wr_en, 1'b0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // 5 Flags register
    drive_id(1'b1, 4'h2, 3'd1, 16'h0001, 3'd2, 16'h0002, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1);
    tick();
    bus.alu_flags = 3'b011;
    drive_id(1'b0, 4'h0, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
    tick();
    check("flags_load", bus.flags_q, 3'b011);
    bus.alu_flags = 3'b100;
    tick();
    check("flags_bubble", bus.flags_q, 3'b011);
    drive_id(1'b1, 4'h4, 3'd1, 16'h0001, 3'd2, 16'h0002, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b1);
    tick();
    bus.stall = 1'b1;
    bus.alu_flags = 3'b110;
    tick();
    check("flags_stall", bus.flags_q, 3'b011);
    bus.stall = 1'b0;
    drive_id(1'b0, 4'h0, 3'd0, 16'h0000, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0);
    tick();
    check("flags_after_stall", bus.flags_q, 3'b110);
    bus.alu_flags = 3'b000;

    // 6 r1 <= r1 + r1 three times; register file still reads the stale r1=1
    r1_model = 16'h0001;
    prev_result = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 4'h0, 3'd1, 16'h0001, 3'd1, 16'h0001, 1'b0, 16'h0000, 1'b1, 3'd1, 1'b0);
      tick();
      // Older result moves to MEM/WB; newest result sits in EX/MEM
      bus.wb_wr_en   = bus.exm_wr_en;
      bus.wb_wr_idx  = 3'd1;
      bus.wb_result  = prev_result;
      bus.exm_wr_en  = (i > 0);
      bus.exm_wr_idx = 3'd1;
      bus.exm_result = r1_model;
      prev_result    = r1_model;
      #1;
      case (i)
        0: check("chain_a0", bus.alu_operand_a, 16'h0001);
        1: check("chain_a1", bus.alu_operand_a, 16'h0002);
        default: check("chain_a2", bus.alu_operand_a, 16'h0004);
      endcase
      check("chain_b", bus.alu_operand_b, r1_model);
      r1_model = r1_model + r1_model;
    end
    no_fwd();

    // Reset mid-stall empties the stage in one cycle
    drive_id(1'b1, 4'h7, 3'd2, 16'h4242, 3'd3, 16'h4343, 1'b0, 16'h0000, 1'b1, 3'd5, 1'b1);
    tick();
    bus.stall = 1'b1;
    rst = 1'b1;
    tick();
    check("rst_stall_valid", bus.ex_valid, 1'b0);
    check("rst_stall_flags", bus.flags_q, 3'b000);
    rst = 1'b0;
    bus.stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
